// File: rtl/pio_write_fifo.sv
// pio_write_fifo: CPU-to-FPGA mailbox. Avalon-MM writes to address 0 are
// buffered in a DEPTH-entry FIFO; the FPGA-side consumer sees the head word
// on rddata while update_avail is high, and acknowledges it with read_rst.
// Status, free-slot count and a sticky overflow flag are readable by the CPU.
module pio_write_fifo #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 4,
   localparam int COUNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // Avalon-MM slave
   input  logic [1:0]            avs_s0_address,
   input  logic                  avs_s0_chipselect,
   input  logic                  avs_s0_write_n,
   input  logic                  avs_s0_read_n,
   input  logic [DATA_WIDTH-1:0] avs_s0_writedata,
   output logic [DATA_WIDTH-1:0] avs_s0_readdata,
   // FPGA-side consumer
   output logic                  update_avail,
   output logic [DATA_WIDTH-1:0] rddata,
   input  logic                  read_rst,
   output logic                  overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_FREE   = 2'd2;

   // Storage and bookkeeping state
   logic [DATA_WIDTH-1:0] storage_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
   logic [COUNT_W-1:0]    count_q,     count_d;
   logic                  overflow_q,  overflow_d;
   logic [DATA_WIDTH-1:0] readdata_q,  readdata_d;

   // Decoded strobes
   logic                  sel;
   logic                  wr_strobe;
   logic                  rd_strobe;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic                  do_store;
   logic                  drop;
   logic                  clr_ovf;

   // Read-side views of the state
   logic [DATA_WIDTH-1:0] head_word;
   logic [DATA_WIDTH-1:0] status_word;
   logic [DATA_WIDTH-1:0] free_word;
   logic [COUNT_W-1:0]    free_slots;
   logic [DATA_WIDTH-1:0] rd_mux;

   // Bus decode and push/pop qualification
   always_comb begin
      sel       = avs_s0_chipselect;
      wr_strobe = sel & ~avs_s0_write_n;
      rd_strobe = sel & ~avs_s0_read_n;
      full      = (count_q == COUNT_W'(DEPTH));
      empty     = (count_q == '0);
      push      = wr_strobe & (avs_s0_address == ADDR_DATA);
      pop       = read_rst & ~empty;
      // A push into a full FIFO still lands if the consumer frees the head
      // slot on the same edge.
      do_store  = push & (~full | pop);
      drop      = push & full & ~pop;
      clr_ovf   = wr_strobe & (avs_s0_address == ADDR_STATUS) & avs_s0_writedata[0];
   end

   // Next-state for pointers, occupancy and the sticky overflow flag
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (do_store) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({do_store, pop})
         2'b10:   count_d = count_q + COUNT_W'(1);
         2'b01:   count_d = count_q - COUNT_W'(1);
         default: count_d = count_q;
      endcase

      // Clear first so that a dropped push in the same cycle wins.
      if (clr_ovf) begin
         overflow_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   // CPU-visible register views and read mux
   always_comb begin
      head_word   = storage_q[rd_ptr_q];
      free_slots  = COUNT_W'(DEPTH) - count_q;
      free_word   = DATA_WIDTH'(free_slots);
      status_word = '0;
      status_word[COUNT_W-1:0]  = count_q;
      status_word[DATA_WIDTH-1] = overflow_q;

      unique case (avs_s0_address)
         ADDR_DATA:   rd_mux = head_word;
         ADDR_STATUS: rd_mux = status_word;
         ADDR_FREE:   rd_mux = free_word;
         default:     rd_mux = '0;
      endcase

      // readdata only moves on a read strobe; otherwise it holds.
      readdata_d = readdata_q;
      if (rd_strobe) begin
         readdata_d = rd_mux;
      end
   end

   // Control state register; reset discards everything immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         readdata_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         readdata_q <= readdata_d;
      end
   end

   // One register per FIFO entry, written only when selected by wr_ptr.
   // Entries are reset so rddata reads 0 after reset even while empty.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the pushed word into this entry when it is the write target
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            storage_q[gi] <= '0;
         end else if (do_store && (wr_ptr_q == PTR_W'(gi))) begin
            storage_q[gi] <= avs_s0_writedata;
         end
      end
   end

   assign avs_s0_readdata = readdata_q;
   assign update_avail    = ~empty;
   assign rddata          = head_word;
   assign overflow        = overflow_q;

endmodule

// File: doc/pio_write_fifo.md
Name: pio_write_fifo

Overview:
- MMIO mailbox through which the CPU pushes words to FPGA logic over an Avalon-MM slave. Words are buffered in a DEPTH-entry FIFO, so back-to-back CPU writes are not lost before the FPGA consumer acknowledges them.
- Status, occupancy and a sticky overflow flag are readable by the CPU.
- Sits between the HPS lightweight bridge and the FPGA-side consumer, for example the PPU or APU command interfaces.

Parameters:
- DATA_WIDTH, 32, word width of data and of Avalon readdata/writedata; must be >= 8 and >= COUNT_W+1.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- COUNT_W, $clog2(DEPTH+1), derived width of the occupancy count; not overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- avs_s0_address  in  2  register select.
- avs_s0_chipselect  in  1  slave select.
- avs_s0_write_n  in  1  active-low write strobe.
- avs_s0_read_n  in  1  active-low read strobe.
- avs_s0_writedata  in  DATA_WIDTH  CPU write data.
- avs_s0_readdata  out  DATA_WIDTH  CPU read data; fixed read latency 1.
- update_avail  out  1  high while the FIFO is non-empty.
- rddata  out  DATA_WIDTH  head-of-FIFO word; valid while update_avail=1.
- read_rst  in  1  consumer ack; pops the head entry.
- overflow  out  1  sticky flag: a CPU push was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - read/write pointers 0, count 0, all storage entries 0;
  - update_avail 0, rddata 0, overflow 0, avs_s0_readdata 0.
- Register map (sel = chipselect):
  - addr 0, write: push writedata.
  - addr 0, read: returns the current head word; no pop.
  - addr 1, read: STATUS = {overflow at bit DATA_WIDTH-1, zeros, count in [COUNT_W-1:0]}.
  - addr 1, write: writedata[0]=1 clears overflow; writedata[0]=0 has no effect.
  - addr 2, read: free slots, DEPTH-count, zero-extended.
  - addr 2 write, and addr 3 read/write: ignored; addr 3 reads return 0.
- push = sel & !write_n & addr==0.
- pop = read_rst & (count!=0). read_rst when empty is ignored; no underflow and no state change.
- Push/pop matrix per cycle:
  - push only, not full: store at wr_ptr; wr_ptr+1 with wrap mod DEPTH; count+1.
  - push only, full: word dropped; overflow<=1; pointers and count unchanged.
  - pop only: rd_ptr+1 with wrap; count-1.
  - push & pop, count between 1 and DEPTH inclusive: both take effect; count unchanged. When full this is legal and nothing is dropped, because the pop frees the slot in the same edge.
  - push & read_rst, empty: push takes effect and pop is ignored; count becomes 1.
- Consumer side:
  - update_avail = (count!=0), derived from registered count.
  - rddata = storage[rd_ptr], combinational from registered state.
  - A pushed word appears on rddata with update_avail=1 in the cycle after the push edge, i.e. 1-cycle latency.
  - After a pop, the next entry is presented the following cycle.
- When empty, rddata shows storage[rd_ptr]: stale, or 0 after reset. Consumers must qualify with update_avail.
- Overflow:
  - set by a dropped push;
  - cleared only by the addr 1 clear write or by reset;
  - set beats clear if both occur in the same cycle.
- Avalon reads: avs_s0_readdata is registered on the edge where sel & !read_n, reflecting pre-edge state. It holds its value otherwise. Reads have no side effects.
- Simultaneous read and write strobes in the same cycle are both honoured.
- Reset mid-operation: all state, including buffered words, is discarded immediately and asynchronously.

Test Plan:
- Reset, then read addr 1 -> readdata 0x00000000; update_avail=0; overflow=0; rddata=0.
- Write 0xA5A5A5A5 to addr 0 -> next cycle update_avail=1, rddata=0xA5A5A5A5. Pulse read_rst -> next cycle update_avail=0, STATUS count=0.
- Push 0x11, 0x22, 0x33, 0x44 back-to-back (DEPTH=4) -> STATUS=0x00000004, addr 2 reads 0. Push 0x55 -> dropped, overflow=1, STATUS=0x80000004. Pop 4 times -> rddata sequence 0x11, 0x22, 0x33, 0x44.
- FIFO full, push 0x66 and pulse read_rst in the same cycle -> count stays 4, overflow stays 0. Drain yields 0x22, 0x33, 0x44, 0x66 (5 pushes total, so pointers wrap).
- Overflow set; write 1 to addr 1 -> STATUS bit31=0. Write 1 to addr 1 in the same cycle as a dropped push -> overflow remains 1.
- Push 2 words, assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, read_rst pulses leave count 0 and update_avail 0.
